// File: rtl/shift_normalizer.sv
// shift_normalizer
//
// Multi-cycle normalizer, the inverse of a barrel shifter. Finds the number of
// leading zeros (Mode=0) or trailing zeros (Mode=1) of a 32-bit operand with a
// binary search, one stage per clock (16, 8, 4, 2, 1). It also returns the
// operand shifted by that amount: left for Mode=0, logical right for Mode=1.
//
// Trailing-zero mode reuses the leading-zero datapath. The operand is
// bit-reversed on accept, and the final work value is reversed back on
// completion.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST_N   in   asynchronous reset, active-low
//   Start   in   request, accepted only in IDLE or DONE
//   A       in   [31:0] operand, sampled with an accepted Start
//   Mode    in   0 = leading-zero (left), 1 = trailing-zero (right)
//   Busy    out  high while the search runs
//   Done    out  one-cycle pulse; Result/Count/Zero valid from this cycle
//   Result  out  [31:0] normalized operand
//   Count   out  [5:0] zero count, 0..32
//   Zero    out  operand was zero
//
// Optional build macro:
//   SHIFT_NORM_EARLY_EXIT_EN - finish as soon as work[31] is set. Results are
//   unchanged and only the latency becomes data-dependent.

module shift_normalizer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic        Mode,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic [5:0]  Count,
  output logic        Zero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  stage_q, stage_d;
  logic        mode_q, mode_d;
  logic [31:0] result_q, result_d;
  logic [5:0]  count_q, count_d;
  logic        zero_q, zero_d;

  // Per-stage test and shift for the current stage index.
  logic        top_zero;
  logic [31:0] work_shifted;

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Stage k tests the top 2^k bits and shifts by 2^k when they are all zero.
  always_comb begin
    top_zero     = 1'b0;
    work_shifted = work_q;
    unique case (stage_q)
      3'd4: begin
        top_zero     = (work_q[31:16] == 16'h0);
        work_shifted = {work_q[15:0], 16'h0};
      end
      3'd3: begin
        top_zero     = (work_q[31:24] == 8'h0);
        work_shifted = {work_q[23:0], 8'h0};
      end
      3'd2: begin
        top_zero     = (work_q[31:28] == 4'h0);
        work_shifted = {work_q[27:0], 4'h0};
      end
      3'd1: begin
        top_zero     = (work_q[31:30] == 2'h0);
        work_shifted = {work_q[29:0], 2'h0};
      end
      3'd0: begin
        top_zero     = (work_q[31] == 1'b0);
        work_shifted = {work_q[30:0], 1'b0};
      end
      default: begin
        top_zero     = 1'b0;
        work_shifted = work_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    mode_d   = mode_q;
    result_d = result_q;
    count_d  = count_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = StRun;
          work_d  = Mode ? bit_reverse(A) : A;
          cnt_d   = 6'd0;
          mode_d  = Mode;
          stage_d = 3'd4;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        if (work_q == 32'h0) begin
          // A zero operand is only possible on the first RUN edge. Shifts never
          // clear the leading one of a nonzero word.
          state_d  = StDone;
          count_d  = 6'd32;
          result_d = 32'h0;
          zero_d   = 1'b1;
`ifdef SHIFT_NORM_EARLY_EXIT_EN
        end else if (work_q[31]) begin
          // Already normalized, so the remaining stages would all be no-ops.
          state_d  = StDone;
          count_d  = cnt_q;
          result_d = mode_q ? bit_reverse(work_q) : work_q;
          zero_d   = 1'b0;
`endif
        end else begin
          if (top_zero) begin
            work_d         = work_shifted;
            cnt_d[stage_q] = 1'b1;
          end
          if (stage_q == 3'd0) begin
            state_d  = StDone;
            count_d  = cnt_d;
            result_d = mode_q ? bit_reverse(work_d) : work_d;
            zero_d   = 1'b0;
          end else begin
            stage_d = stage_q - 3'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      work_q   <= 32'h0;
      cnt_q    <= 6'd0;
      stage_q  <= 3'd0;
      mode_q   <= 1'b0;
      result_q <= 32'h0;
      count_q  <= 6'd0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      count_q  <= count_d;
      zero_q   <= zero_d;
    end
  end

  // Status outputs decode straight from the state flop, so they are glitch-free.
  assign Busy   = (state_q == StRun);
  assign Done   = (state_q == StDone);
  assign Result = result_q;
  assign Count  = count_q;
  assign Zero   = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

  logic        CLK;
  logic        RST_N;
  logic        Start;
  logic [31:0] A;
  logic        Mode;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic [5:0]  Count;
  logic        Zero;

  int vectors = 0;
  int miscompares = 0;

  shift_normalizer dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .Start  (Start),
    .A      (A),
    .Mode   (Mode),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Count  (Count),
    .Zero   (Zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int clz(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) if (a[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int ctz(input logic [31:0] a);
    for (int i = 0; i < 32; i++) if (a[i]) return i;
    return 32;
  endfunction

  function automatic int zcount(input logic [31:0] a, input logic m);
    return m ? ctz(a) : clz(a);
  endfunction

  function automatic logic [31:0] norm_res(input logic [31:0] a, input logic m);
    int z;
    z = zcount(a, m);
    if (z >= 32) return 32'h0;
    return m ? (a >> z) : (a << z);
  endfunction

  // Edges after the accept edge until the one that enters DONE.
  function automatic int exp_lat(input logic [31:0] a, input logic m);
    int z;
    if (a == 32'h0) return 1;
    z = zcount(a, m);
`ifdef SHIFT_NORM_EARLY_EXIT_EN
    // After j search stages the count is known down to a multiple of 32>>j.
    // The word is normalized once the true count is such a multiple.
    for (int j = 0; j < 5; j++) if (z % (32 >> j) == 0) return 1 + j;
`endif
    return 5;
  endfunction

  int          m_rem = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [5:0]  m_cnt = '0;
  logic        m_zero = 1'b0;
  logic [31:0] p_res = '0;
  logic [5:0]  p_cnt = '0;
  logic        p_zero = 1'b0;

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_rem = 0; m_done = 0; m_res = '0; m_cnt = '0; m_zero = 0;
      end else begin
        logic dn;
        dn = 1'b0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            dn = 1'b1; m_res = p_res; m_cnt = p_cnt; m_zero = p_zero;
          end
        end else if (Start) begin
          p_res  = norm_res(A, Mode);
          p_cnt  = 6'(zcount(A, Mode));
          p_zero = (A == 32'h0);
          m_rem  = exp_lat(A, Mode);
        end
        m_done = dn;
      end
    end
  end

  // Compare process: the outputs are defined every cycle, so check them on every negedge.
  always @(negedge CLK) begin
    chk("busy", {31'h0, Busy}, {31'h0, (m_rem > 0)});
    chk("done", {31'h0, Done}, {31'h0, m_done});
    chk("result", Result, m_res);
    chk("count", {26'h0, Count}, {26'h0, m_cnt});
    chk("zero", {31'h0, Zero}, {31'h0, m_zero});
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!Done && lat < 20) begin
      busy_n += int'(Busy);
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
    chk("done_seen", {31'h0, Done}, 32'h1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic m, input logic [5:0] ec,
                        input logic [31:0] er, input logic ez, input int el);
    int lat;
    int busy_n;
    @(negedge CLK);
    Start = 1'b1; A = a; Mode = m;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    wait_done(lat, busy_n);
    chk("lit_latency", lat, el);
    chk("lit_busy_cycles", busy_n, el);
    chk("lit_count", {26'h0, Count}, {26'h0, ec});
    chk("lit_result", Result, er);
    chk("lit_zero", {31'h0, Zero}, {31'h0, ez});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_n;
    int pulses;
    int last;
    Start = 1'b0; A = '0; Mode = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    @(negedge CLK);
    chk("reset_busy", {31'h0, Busy}, 32'h0);
    chk("reset_done", {31'h0, Done}, 32'h0);
    chk("reset_result", Result, 32'h0);
    chk("reset_count", {26'h0, Count}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_op(32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0, 5);
`ifdef SHIFT_NORM_EARLY_EXIT_EN
    run_op(32'h8000_0000, 1'b0, 6'd0, 32'h8000_0000, 1'b0, 1);
`else
    run_op(32'h8000_0000, 1'b0, 6'd0, 32'h8000_0000, 1'b0, 5);
`endif
    run_op(32'h0001_0000, 1'b1, 6'd16, 32'h0000_0001, 1'b0, exp_lat(32'h0001_0000, 1'b1));
    run_op(32'h0000_0F00, 1'b1, 6'd8, 32'h0000_000F, 1'b0, exp_lat(32'h0000_0F00, 1'b1));
    run_op(32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1, 1);
    run_op(32'h0000_0000, 1'b1, 6'd32, 32'h0000_0000, 1'b1, 1);
    run_op(32'h00F0_0000, 1'b0, 6'd8, 32'hF000_0000, 1'b0, exp_lat(32'h00F0_0000, 1'b0));
    run_op(32'h1234_5678, 1'b1, 6'd3, 32'h0246_8ACF, 1'b0, exp_lat(32'h1234_5678, 1'b1));
    run_op(32'hFFFF_FFFF, 1'b1, 6'd0, 32'hFFFF_FFFF, 1'b0, exp_lat(32'hFFFF_FFFF, 1'b1));

    // A Start while running is ignored.
    @(negedge CLK);
    Start = 1'b1; A = 32'h1; Mode = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b1; A = 32'hFFFF_FFFF;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    wait_done(lat, busy_n);
    chk("ign_latency", lat + 2, 5);
    chk("ign_count", {26'h0, Count}, 32'd31);
    chk("ign_result", Result, 32'h8000_0000);

    // A new request is accepted in the DONE cycle, then aborted by reset.
    Start = 1'b1; A = 32'h0000_0100; Mode = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    @(negedge CLK);
    chk("abort_busy", {31'h0, Busy}, 32'h0);
    chk("abort_result", Result, 32'h0);
    chk("abort_count", {26'h0, Count}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("abort_no_done", {31'h0, Done}, 32'h0);
    end
    run_op(32'h0000_0100, 1'b0, 6'd23, 32'h8000_0000, 1'b0, exp_lat(32'h0000_0100, 1'b0));

    // With Start held high, the unit restarts from every DONE cycle.
    pulses = 0;
    last = -1;
    @(negedge CLK);
    Start = 1'b1; A = 32'h00F0_0000; Mode = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (Done) begin
        pulses++;
        chk("cont_count", {26'h0, Count}, 32'd8);
        chk("cont_result", Result, 32'hF000_0000);
        if (last >= 0) chk("cont_spacing", c - last, exp_lat(32'h00F0_0000, 1'b0) + 1);
        last = c;
      end
    end
    Start = 1'b0;
    chk("cont_pulses_ge4", {31'h0, (pulses >= 4)}, 32'h1);

    repeat (8) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
